// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - arbitrates the data-memory port between loads and committed stores
// Registered request/response path; store starvation is bounded by STARVE_MAX lost arbitrations.
module lsu_mem_arbiter #(
   parameter int TAG_W      = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [31:0]      ld_addr,
   input  logic [2:0]       ld_size,
   input  logic [TAG_W-1:0] ld_tag,
   input  logic             st_valid,
   output logic             st_ready,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   input  logic [1:0]       st_size,
   input  logic             st_urgent,
   input  logic             flush,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [31:0]      mem_rdata,
   output logic             ld_resp_valid,
   output logic [31:0]      ld_resp_data,
   output logic [TAG_W-1:0] ld_resp_tag,
   output logic             busy
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e             state_q;
   logic               is_load_q;
   logic               squash_q;
   logic [1:0]         off_q;
   logic [2:0]         size_q;
   logic [TAG_W-1:0]   tag_q;
   logic [CNT_W-1:0]   starve_q, starve_d;
   logic               mem_req_q, mem_we_q;
   logic [31:0]        mem_addr_q, mem_wdata_q;
   logic [3:0]         mem_be_q;
   logic               ld_resp_valid_q;
   logic [31:0]        ld_resp_data_q;
   logic [TAG_W-1:0]   ld_resp_tag_q;

   logic               idle;
   logic               store_prio;
   logic               ld_win;

   function automatic logic [3:0] store_be(input logic [1:0] off, input logic [1:0] size);
      case (size)
         2'b00:   store_be = 4'b0001 << off;
         2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
         default: store_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [31:0] data, input logic [1:0] size);
      case (size)
         2'b00:   store_wdata = {4{data[7:0]}};
         2'b01:   store_wdata = {2{data[15:0]}};
         default: store_wdata = data;
      endcase
   endfunction

   // Size x11 falls through to the word case.
   function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [2:0] size);
      logic [31:0] sh;
      sh = '0;
      case (size[1:0])
         2'b00: begin
            sh = rdata >> {off, 3'b000};
            load_extend = {{24{size[2] & sh[7]}}, sh[7:0]};
         end
         2'b01: begin
            sh = rdata >> {off[1], 4'b0000};
            load_extend = {{16{size[2] & sh[15]}}, sh[15:0]};
         end
         default: load_extend = rdata;
      endcase
   endfunction

   assign idle       = (state_q == IDLE);
   assign store_prio = st_urgent || (starve_q >= CNT_MAX);
   assign ld_win     = ld_valid && !flush && !(st_valid && store_prio);
   assign ld_ready   = idle && ld_win;
   assign st_ready   = idle && st_valid && !ld_win;

   always_comb begin
      starve_d = starve_q;
      if (st_ready) begin
         starve_d = '0;
      end else if (ld_ready && st_valid && (starve_q != CNT_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         is_load_q       <= 1'b0;
         squash_q        <= 1'b0;
         off_q           <= '0;
         size_q          <= '0;
         tag_q           <= '0;
         starve_q        <= '0;
         mem_req_q       <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         mem_be_q        <= '0;
         ld_resp_valid_q <= 1'b0;
         ld_resp_data_q  <= '0;
         ld_resp_tag_q   <= '0;
      end else begin
         ld_resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               starve_q <= starve_d;
               squash_q <= 1'b0;
               if (ld_ready) begin
                  state_q     <= REQ;
                  is_load_q   <= 1'b1;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= {ld_addr[31:2], 2'b00};
                  mem_wdata_q <= '0;
                  mem_be_q    <= 4'b1111;
                  off_q       <= ld_addr[1:0];
                  size_q      <= ld_size;
                  tag_q       <= ld_tag;
               end else if (st_ready) begin
                  state_q     <= REQ;
                  is_load_q   <= 1'b0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {st_addr[31:2], 2'b00};
                  mem_wdata_q <= store_wdata(st_data, st_size);
                  mem_be_q    <= store_be(st_addr[1:0], st_size);
               end
            end
            REQ: begin
               // The request is never withdrawn; a flush only marks the load as squashed.
               if (is_load_q && flush) begin
                  squash_q <= 1'b1;
               end
               if (mem_gnt) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= is_load_q ? WAIT : IDLE;
               end
            end
            WAIT: begin
               if (flush) begin
                  squash_q <= 1'b1;
               end
               if (mem_rvalid) begin
                  state_q         <= IDLE;
                  squash_q        <= 1'b0;
                  ld_resp_valid_q <= !(squash_q || flush);
                  ld_resp_data_q  <= load_extend(mem_rdata, off_q, size_q);
                  ld_resp_tag_q   <= tag_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_be        = mem_be_q;
   assign ld_resp_valid = ld_resp_valid_q;
   assign ld_resp_data  = ld_resp_data_q;
   assign ld_resp_tag   = ld_resp_tag_q;
   assign busy          = !idle;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - directed self-checking bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid, ld_ready;
   logic [31:0] ld_addr;
   logic [2:0]  ld_size;
   logic [3:0]  ld_tag;
   logic        st_valid, st_ready;
   logic [31:0] st_addr, st_data;
   logic [1:0]  st_size;
   logic        st_urgent, flush;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        ld_resp_valid;
   logic [31:0] ld_resp_data;
   logic [3:0]  ld_resp_tag;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   lsu_mem_arbiter #(.TAG_W(4), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_size(ld_size), .ld_tag(ld_tag),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
      .st_urgent(st_urgent), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_tag(ld_resp_tag),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 20) begin
         step();
         k++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] tag,
                          input logic [31:0] rdata, input logic [31:0] exp_data);
      ld_valid = 1'b1; ld_addr = addr; ld_size = size; ld_tag = tag;
      #1;
      chk("ld_ready", 32'(ld_ready), 32'd1);
      chk("ld_st_ready", 32'(st_ready), 32'd0);
      step();
      ld_valid = 1'b0;
      chk("ld_mem_req", 32'(mem_req), 32'd1);
      chk("ld_mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("ld_mem_be", 32'(mem_be), 32'hF);
      chk("ld_mem_we", 32'(mem_we), 32'd0);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
      chk("ld_req_drop", 32'(mem_req), 32'd0);
      chk("ld_resp_early", 32'(ld_resp_valid), 32'd0);
      step();
      mem_rvalid = 1'b0;
      chk("ld_resp_valid", 32'(ld_resp_valid), 32'd1);
      chk("ld_resp_data", ld_resp_data, exp_data);
      chk("ld_resp_tag", 32'(ld_resp_tag), 32'(tag));
      chk("ld_busy_done", 32'(busy), 32'd0);
      step();
      chk("ld_resp_pulse", 32'(ld_resp_valid), 32'd0);
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                           input int gnt_delay, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      st_valid = 1'b1; st_addr = addr; st_data = data; st_size = size;
      #1;
      chk("st_ready", 32'(st_ready), 32'd1);
      step();
      chk("st_mem_we", 32'(mem_we), 32'd1);
      chk("st_mem_be", 32'(mem_be), 32'(exp_be));
      chk("st_mem_wdata", mem_wdata, exp_wdata);
      chk("st_mem_addr", mem_addr, {addr[31:2], 2'b00});
      for (int c = 1; c <= gnt_delay; c++) begin
         chk("st_req_held", 32'(mem_req), 32'd1);
         chk("st_ready_busy", 32'(st_ready), 32'd0);
         if (c == gnt_delay) begin
            mem_gnt = 1'b1;
            st_valid = 1'b0;
         end
         step();
      end
      mem_gnt = 1'b0;
      chk("st_req_done", 32'(mem_req), 32'd0);
      chk("st_busy_done", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      ld_valid = 0; ld_addr = 0; ld_size = 0; ld_tag = 0;
      st_valid = 0; st_addr = 0; st_data = 0; st_size = 0;
      st_urgent = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      step();
      step();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_resp_valid", 32'(ld_resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_readies", {30'd0, ld_ready, st_ready}, 32'd0);
      rst_n = 1'b1;
      step();

      do_load(32'h0000_0103, 3'b100, 4'hA, 32'h80FF_1234, 32'hFFFF_FF80);
      do_load(32'h0000_0101, 3'b000, 4'h3, 32'h80FF_1234, 32'h0000_0012);
      do_load(32'h0000_0002, 3'b001, 4'h4, 32'h80FF_1234, 32'h0000_80FF);
      do_load(32'h0000_0002, 3'b101, 4'h5, 32'h80FF_1234, 32'hFFFF_80FF);
      do_load(32'h0000_0011, 3'b111, 4'h6, 32'h80FF_1234, 32'h80FF_1234);

      do_store(32'h0000_0206, 32'h0000_BEEF, 2'b01, 3, 4'b1100, 32'hBEEF_BEEF);
      do_store(32'h0000_0003, 32'h1234_5678, 2'b00, 1, 4'b1000, 32'h7878_7878);
      do_store(32'h0000_0012, 32'hDEAD_BEEF, 2'b10, 1, 4'b1111, 32'hDEAD_BEEF);

      // Contention with an always-ready memory.
      mem_gnt = 1'b1; mem_rvalid = 1'b1;
      ld_valid = 1'b1; ld_addr = 32'h40; ld_size = 3'b010; ld_tag = 4'h1;
      st_valid = 1'b1; st_addr = 32'h80; st_data = 32'h1; st_size = 2'b10;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("cont_ld_wins", {30'd0, ld_ready, st_ready}, 32'b10);
         step();
         wait_idle();
      end
      chk("cont_st_wins", {30'd0, ld_ready, st_ready}, 32'b01);
      step();
      wait_idle();
      chk("cont_starve_clr", {30'd0, ld_ready, st_ready}, 32'b10);
      st_urgent = 1'b1;
      #1;
      chk("cont_urgent", {30'd0, ld_ready, st_ready}, 32'b01);
      ld_valid = 0; st_valid = 0; st_urgent = 0; mem_gnt = 0; mem_rvalid = 0;
      step();

      // Flush in WAIT squashes the response.
      ld_valid = 1'b1; ld_addr = 32'h44; ld_size = 3'b010; ld_tag = 4'h7;
      step();
      ld_valid = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; flush = 1'b1;
      chk("fl_busy_wait", 32'(busy), 32'd1);
      step();
      flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      step();
      mem_rvalid = 1'b0;
      chk("fl_resp_squashed", 32'(ld_resp_valid), 32'd0);
      chk("fl_idle", 32'(busy), 32'd0);
      step();
      chk("fl_resp_later", 32'(ld_resp_valid), 32'd0);

      flush = 1'b1; ld_valid = 1'b1; st_valid = 1'b1;
      st_addr = 32'h90; st_data = 32'hA5; st_size = 2'b00;
      #1;
      chk("fl_store_acc", {30'd0, ld_ready, st_ready}, 32'b01);
      step();
      flush = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
      chk("fl_store_we", 32'(mem_we), 32'd1);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;

      // Asynchronous reset while a load waits for data.
      ld_valid = 1'b1; ld_addr = 32'h300; ld_size = 3'b010; ld_tag = 4'h9;
      step();
      ld_valid = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("rw_busy_pre", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rw_busy", 32'(busy), 32'd0);
      chk("rw_mem_req", 32'(mem_req), 32'd0);
      chk("rw_mem_addr", mem_addr, 32'd0);
      chk("rw_mem_be", 32'(mem_be), 32'd0);
      chk("rw_mem_wdata", mem_wdata, 32'd0);
      chk("rw_resp_tag", 32'(ld_resp_tag), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      do_load(32'h0000_0000, 3'b010, 4'h5, 32'hCAFE_F00D, 32'hCAFE_F00D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
